// File: rtl/slave_mem_initiator.sv
// slave_mem_initiator: turns a valid/ready command into a single port-0 slave
// memory access, waits for completion or timeout, and returns a held response.
module slave_mem_initiator #(
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    output logic [1:0]            S_oe_ram,
    output logic [1:0]            S_we_ram,
    output logic [2*ADDR_W-1:0]   S_addr_ram,
    output logic [2*DATA_W-1:0]   S_Wdata_ram,
    output logic [7:0]            S_data_ram_size,
    input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
    input  logic [1:0]            Sout_DataRdy
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              accept;
    logic              done;
    logic              expire;

    // Port-1 completion and read data are never consumed.
    logic unused_port1;
    assign unused_port1 = &{1'b0, Sout_DataRdy[1], Sout_Rdata_ram[2*DATA_W-1:DATA_W]};

    // Handshake and access-termination conditions; completion wins over timeout.
    assign accept = (state == IDLE) && cmd_valid && reset;
    assign done   = (state == ACCESS) && Sout_DataRdy[0];
    assign expire = (state == ACCESS) && !Sout_DataRdy[0] && (cnt_q == CNT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ACCESS;
            ACCESS:  if (done || expire) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command latch, timeout counter and response capture.
    always_ff @(posedge clock) begin
        if (!reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= cmd_we;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                cnt_q   <= '0;
            end
            if (done) begin
                rdata_q <= we_q ? '0 : Sout_Rdata_ram[DATA_W-1:0];
                err_q   <= 1'b0;
            end else if (expire) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end else if (state == ACCESS) begin
                cnt_q   <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Output decode: port-0 strobes only during ACCESS, port-1 lanes tied off.
    always_comb begin
        cmd_ready       = 1'b0;
        rsp_valid       = 1'b0;
        busy            = (state != IDLE);
        rsp_rdata       = rdata_q;
        rsp_err         = err_q;
        S_oe_ram        = '0;
        S_we_ram        = '0;
        S_addr_ram      = '0;
        S_Wdata_ram     = '0;
        S_data_ram_size = '0;
        case (state)
            IDLE:   cmd_ready = reset;
            ACCESS: begin
                S_we_ram[0]                = we_q;
                S_oe_ram[0]                = ~we_q;
                S_addr_ram[ADDR_W-1:0]     = addr_q;
                S_Wdata_ram[DATA_W-1:0]    = wdata_q;
                S_data_ram_size[3:0]       = 4'(DATA_W);
            end
            RESP:   rsp_valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_slave_mem_initiator.sv
// Directed bench for slave_mem_initiator with hand-computed expectations.
module tb_slave_mem_initiator;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;

    logic                clock = 1'b0;
    logic                reset;
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_we;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;
    logic                busy;
    logic [1:0]          S_oe_ram;
    logic [1:0]          S_we_ram;
    logic [2*ADDR_W-1:0] S_addr_ram;
    logic [2*DATA_W-1:0] S_Wdata_ram;
    logic [7:0]          S_data_ram_size;
    logic [2*DATA_W-1:0] Sout_Rdata_ram;
    logic [1:0]          Sout_DataRdy;

    int checks = 0;
    int errors = 0;

    slave_mem_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(16)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
        .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
        .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_oe"},   32'(S_oe_ram), 32'h0);
        check({tag, "_we"},   32'(S_we_ram), 32'h0);
        check({tag, "_addr"}, 32'(S_addr_ram), 32'h0);
        check({tag, "_wd"},   32'(S_Wdata_ram), 32'h0);
        check({tag, "_size"}, 32'(S_data_ram_size), 32'h0);
    endtask

    task automatic offer(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wd;
    endtask

    int acc_first;
    int acc_second;

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; Sout_Rdata_ram = '0; Sout_DataRdy = '0;
        step(); step();

        // Reset state
        check("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'h0);
        check_idle_outputs("rst");
        reset = 1'b1;
        #1;
        check("rel_cmd_ready", 32'(cmd_ready), 32'h1);

        // Read, immediate completion; DataRdy already high in IDLE is ignored
        Sout_Rdata_ram = 16'hFFA7;
        Sout_DataRdy   = 2'b01;
        rsp_ready      = 1'b1;
        offer(1'b0, 7'h05, 8'h55);
        step();
        cmd_valid = 1'b0; cmd_addr = 7'h11; cmd_we = 1'b1;
        #1;
        check("rd_acc_oe", 32'(S_oe_ram), 32'h1);
        check("rd_acc_we", 32'(S_we_ram), 32'h0);
        check("rd_acc_addr", 32'(S_addr_ram), 32'h0005);
        check("rd_acc_size", 32'(S_data_ram_size), 32'h08);
        check("rd_acc_busy", 32'(busy), 32'h1);
        check("rd_acc_ready", 32'(cmd_ready), 32'h0);
        step();
        check("rd_rsp_valid", 32'(rsp_valid), 32'h1);
        check("rd_rsp_rdata", 32'(rsp_rdata), 32'hA7);
        check("rd_rsp_err", 32'(rsp_err), 32'h0);
        check("rd_rsp_ready", 32'(cmd_ready), 32'h0);
        check_idle_outputs("rd_rsp");
        Sout_DataRdy = 2'b00;
        step();
        check("rd_back_valid", 32'(rsp_valid), 32'h0);
        check("rd_back_ready", 32'(cmd_ready), 32'h1);
        check("rd_back_busy", 32'(busy), 32'h0);

        // Write, completion in the third ACCESS cycle, then backpressure
        rsp_ready = 1'b0;
        offer(1'b1, 7'h7F, 8'h3C);
        step();
        cmd_valid = 1'b0; cmd_wdata = 8'hFF; cmd_addr = 7'h00;
        for (int i = 0; i < 3; i++) begin
            check("wr_acc_we", 32'(S_we_ram), 32'h1);
            check("wr_acc_oe", 32'(S_oe_ram), 32'h0);
            check("wr_acc_wd", 32'(S_Wdata_ram), 32'h003C);
            check("wr_acc_addr", 32'(S_addr_ram), 32'h007F);
            check("wr_acc_size", 32'(S_data_ram_size), 32'h08);
            if (i == 2) begin
                Sout_DataRdy = 2'b01;
                Sout_Rdata_ram = 16'h00EE;
            end
            step();
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(rsp_valid), 32'h1);
            check("bp_rdata", 32'(rsp_rdata), 32'h00);
            check("bp_err", 32'(rsp_err), 32'h0);
            check("bp_ready", 32'(cmd_ready), 32'h0);
            check("bp_we", 32'(S_we_ram), 32'h0);
            Sout_DataRdy   = (i % 2 == 0) ? 2'b11 : 2'b10;
            Sout_Rdata_ram = 16'(16'h1234 + i);
            step();
        end
        Sout_DataRdy = 2'b00;
        rsp_ready = 1'b1;
        step();
        check("bp_done_valid", 32'(rsp_valid), 32'h0);
        check("bp_done_ready", 32'(cmd_ready), 32'h1);

        // Timeout: read strobe for exactly 16 cycles, then error response
        Sout_Rdata_ram = 16'h00C3;
        offer(1'b0, 7'h22, 8'h00);
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("to_oe", 32'(S_oe_ram), 32'h1);
            check("to_valid", 32'(rsp_valid), 32'h0);
            step();
        end
        check("to_rsp_valid", 32'(rsp_valid), 32'h1);
        check("to_rsp_err", 32'(rsp_err), 32'h1);
        check("to_rsp_rdata", 32'(rsp_rdata), 32'h0);
        check("to_rsp_oe", 32'(S_oe_ram), 32'h0);
        step();

        // Completion in the last timeout cycle counts as success
        Sout_Rdata_ram = 16'h005A;
        offer(1'b0, 7'h33, 8'h00);
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check("last_oe", 32'(S_oe_ram), 32'h1);
        Sout_DataRdy = 2'b01;
        step();
        Sout_DataRdy = 2'b00;
        check("last_valid", 32'(rsp_valid), 32'h1);
        check("last_err", 32'(rsp_err), 32'h0);
        check("last_rdata", 32'(rsp_rdata), 32'h5A);
        step();

        // Reset in the second ACCESS cycle aborts the access silently
        offer(1'b0, 7'h44, 8'h00);
        step();
        cmd_valid = 1'b0;
        step();
        check("rma_oe", 32'(S_oe_ram), 32'h1);
        reset = 1'b0;
        Sout_DataRdy = 2'b01;
        #1;
        check("rma_ready_low", 32'(cmd_ready), 32'h0);
        step();
        check("rma_busy", 32'(busy), 32'h0);
        check("rma_valid", 32'(rsp_valid), 32'h0);
        check("rma_err", 32'(rsp_err), 32'h0);
        check("rma_rdata", 32'(rsp_rdata), 32'h0);
        check_idle_outputs("rma");
        reset = 1'b1;
        Sout_DataRdy = 2'b00;
        #1;
        check("rma_ready_rel", 32'(cmd_ready), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rma_no_rsp", 32'(rsp_valid), 32'h0);
        end

        // Back-to-back reads with immediate completion
        Sout_Rdata_ram = 16'hF033;
        Sout_DataRdy   = 2'b11;
        rsp_ready      = 1'b1;
        acc_first  = -1;
        acc_second = -100;
        offer(1'b0, 7'h10, 8'h00);
        for (int c = 0; c < 12; c++) begin
            check("b2b_p1_oe", 32'(S_oe_ram[1]), 32'h0);
            check("b2b_p1_we", 32'(S_we_ram[1]), 32'h0);
            check("b2b_p1_addr", 32'(S_addr_ram[2*ADDR_W-1:ADDR_W]), 32'h0);
            check("b2b_p1_wd", 32'(S_Wdata_ram[2*DATA_W-1:DATA_W]), 32'h0);
            check("b2b_p1_size", 32'(S_data_ram_size[7:4]), 32'h0);
            if (rsp_valid) check("b2b_rdata", 32'(rsp_rdata), 32'h33);
            if (cmd_valid && cmd_ready) begin
                if (acc_first < 0) begin
                    acc_first = c;
                    cmd_addr  = 7'h11;
                end else begin
                    acc_second = c;
                end
            end
            step();
            if (acc_second >= 0) cmd_valid = 1'b0;
        end
        check("b2b_spacing", 32'(acc_second - acc_first), 32'd3);
        Sout_DataRdy = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
